// File: rtl/coasia_pkg.sv
// Shared types for the coasia_if approval protocol.
//  approval_e        : verdict carried on the approval wire (2'd3 is never a verdict)
//  lang_cer_e        : language certificate class of an applicant
//  applicant_state_e : state encoding of the coasia_applicant FSM
package coasia_pkg;

    typedef enum logic [1:0] {
        UNKNOWN = 2'd0,
        ACCEPT  = 2'd1,
        REJECT  = 2'd2
    } approval_e;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        KIIP  = 2'd1,
        TOPIK = 2'd2,
        OTHER = 2'd3
    } lang_cer_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        GAP   = 3'd4
    } applicant_state_e;

    // Only ACCEPT and REJECT end a WAIT; UNKNOWN and the unused code 3 do not.
    function automatic logic is_verdict(input logic [1:0] a);
        return (a == ACCEPT) || (a == REJECT);
    endfunction

endpackage

// File: rtl/coasia_applicant_timer.sv
// WAIT-phase timeout timer for coasia_applicant.
//  clk     : clock
//  rst_n   : asynchronous active-low reset
//  clear   : synchronous clear to zero (wins over enable)
//  enable  : count one WAIT cycle without a verdict
//  expire  : counter has reached TIMEOUT_CYC-1
module coasia_applicant_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC - 1);

    logic [7:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 8'd0;
        end else if (clear) begin
            count_reg <= 8'd0;
        end else if (enable) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign expire = (count_reg == LIMIT);

endmodule

// File: rtl/coasia_applicant.sv
// Initiator end of the coasia_if approval protocol.
// Takes one application on the req_* valid/ready port, presents it to the
// approval responder on kore_sub/lang_cer, and returns the verdict (or a
// timeout) on the rsp_* valid/ready port. One application outstanding.
//  clk, rst_n            : clock, asynchronous active-low reset
//  req_valid/req_ready   : request handshake (ready only in IDLE)
//  req_lang_cer          : lang_cer_e of the applicant
//  rsp_valid/rsp_ready   : response handshake
//  rsp_approval          : approval_e verdict (UNKNOWN on timeout)
//  rsp_timeout           : no verdict within TIMEOUT_CYC WAIT cycles
//  kore_sub, lang_cer    : to responder
//  approval              : from responder
//  busy                  : FSM not in IDLE
//  accept_cnt/reject_cnt/timeout_cnt : saturating statistics, present only
//                          when COASIA_APPLICANT_STATS_EN is defined
module coasia_applicant
    import coasia_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
`ifdef COASIA_APPLICANT_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_lang_cer,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [1:0] rsp_approval,
    output logic       rsp_timeout,
    output logic       kore_sub,
    output logic [1:0] lang_cer,
    input  logic [1:0] approval,
    output logic       busy
`ifdef COASIA_APPLICANT_STATS_EN
    ,
    output logic [CNT_W-1:0] accept_cnt,
    output logic [CNT_W-1:0] reject_cnt,
    output logic [CNT_W-1:0] timeout_cnt
`endif
);

    applicant_state_e state_reg, state_next;

    logic       req_ready_reg, req_ready_next;
    logic       busy_reg, busy_next;
    logic       kore_sub_reg, kore_sub_next;
    logic [1:0] lang_cer_reg, lang_cer_next;
    logic       rsp_valid_reg, rsp_valid_next;
    logic [1:0] rsp_approval_reg, rsp_approval_next;
    logic       rsp_timeout_reg, rsp_timeout_next;

    logic timer_clear;
    logic timer_enable;
    logic timer_expire;

    coasia_applicant_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expire (timer_expire)
    );

    always_comb begin
        state_next        = state_reg;
        kore_sub_next     = kore_sub_reg;
        lang_cer_next     = lang_cer_reg;
        rsp_valid_next    = rsp_valid_reg;
        rsp_approval_next = rsp_approval_reg;
        rsp_timeout_next  = rsp_timeout_reg;
        timer_clear       = 1'b0;
        timer_enable      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req_valid && req_ready_reg) begin
                    lang_cer_next = req_lang_cer;
                    kore_sub_next = 1'b1;
                    state_next    = APPLY;
                end
            end
            APPLY: begin
                kore_sub_next = 1'b1;
                timer_clear   = 1'b1;
                state_next    = WAIT;
            end
            WAIT: begin
                // A verdict arriving on the expiry cycle still counts as a verdict.
                if (is_verdict(approval)) begin
                    rsp_approval_next = approval;
                    rsp_timeout_next  = 1'b0;
                    rsp_valid_next    = 1'b1;
                    kore_sub_next     = 1'b0;
                    state_next        = RESP;
                end else if (timer_expire) begin
                    rsp_approval_next = UNKNOWN;
                    rsp_timeout_next  = 1'b1;
                    rsp_valid_next    = 1'b1;
                    kore_sub_next     = 1'b0;
                    state_next        = RESP;
                end else begin
                    timer_enable = 1'b1;
                end
            end
            RESP: begin
                if (rsp_valid_reg && rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    lang_cer_next  = NONE;
                    state_next     = GAP;
                end
            end
            GAP: begin
                // Hold off the next application until the responder has
                // dropped its previous verdict, so WAIT never sees it.
                kore_sub_next = 1'b0;
                lang_cer_next = NONE;
                if (approval == UNKNOWN) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Handshake/status flags are registered from the next state so they
        // line up with the state they describe.
        req_ready_next = (state_next == IDLE);
        busy_next      = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            req_ready_reg    <= 1'b0;
            busy_reg         <= 1'b0;
            kore_sub_reg     <= 1'b0;
            lang_cer_reg     <= NONE;
            rsp_valid_reg    <= 1'b0;
            rsp_approval_reg <= UNKNOWN;
            rsp_timeout_reg  <= 1'b0;
        end else begin
            state_reg        <= state_next;
            req_ready_reg    <= req_ready_next;
            busy_reg         <= busy_next;
            kore_sub_reg     <= kore_sub_next;
            lang_cer_reg     <= lang_cer_next;
            rsp_valid_reg    <= rsp_valid_next;
            rsp_approval_reg <= rsp_approval_next;
            rsp_timeout_reg  <= rsp_timeout_next;
        end
    end

    assign req_ready    = req_ready_reg;
    assign busy         = busy_reg;
    assign kore_sub     = kore_sub_reg;
    assign lang_cer     = lang_cer_reg;
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_approval = rsp_approval_reg;
    assign rsp_timeout  = rsp_timeout_reg;

`ifdef COASIA_APPLICANT_STATS_EN
    logic [CNT_W-1:0] accept_cnt_reg, reject_cnt_reg, timeout_cnt_reg;
    logic             rsp_fire;

    assign rsp_fire = (state_reg == RESP) && rsp_valid_reg && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accept_cnt_reg  <= '0;
            reject_cnt_reg  <= '0;
            timeout_cnt_reg <= '0;
        end else if (rsp_fire) begin
            if (rsp_timeout_reg) begin
                if (timeout_cnt_reg != '1) timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
            end else if (rsp_approval_reg == ACCEPT) begin
                if (accept_cnt_reg != '1) accept_cnt_reg <= accept_cnt_reg + 1'b1;
            end else if (rsp_approval_reg == REJECT) begin
                if (reject_cnt_reg != '1) reject_cnt_reg <= reject_cnt_reg + 1'b1;
            end
        end
    end

    assign accept_cnt  = accept_cnt_reg;
    assign reject_cnt  = reject_cnt_reg;
    assign timeout_cnt = timeout_cnt_reg;
`endif

endmodule

// File: tb/tb_coasia_applicant.sv
// Directed bench for coasia_applicant paired with a behavioural approval
// responder (ACCEPT for lang_cer NONE, REJECT otherwise, registered one
// cycle after kore_sub) that can be overridden by a stub value.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_coasia_applicant;
    import coasia_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_lang_cer = 2'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [1:0] rsp_approval;
    logic       rsp_timeout;
    logic       kore_sub;
    logic [1:0] lang_cer;
    logic [1:0] approval;
    logic       busy;
`ifdef COASIA_APPLICANT_STATS_EN
    logic [3:0] accept_cnt, reject_cnt, timeout_cnt;
`endif

    logic       stub_en = 1'b0;
    logic [1:0] stub_val = 2'd0;
    logic [1:0] approval_model = 2'd0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (kore_sub) approval_model <= (lang_cer == NONE) ? ACCEPT : REJECT;
        else          approval_model <= UNKNOWN;
    end
    assign approval = stub_en ? stub_val : approval_model;

    coasia_applicant #(
        .TIMEOUT_CYC(16)
`ifdef COASIA_APPLICANT_STATS_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_lang_cer (req_lang_cer),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_approval (rsp_approval),
        .rsp_timeout  (rsp_timeout),
        .kore_sub     (kore_sub),
        .lang_cer     (lang_cer),
        .approval     (approval),
        .busy         (busy)
`ifdef COASIA_APPLICANT_STATS_EN
        , .accept_cnt  (accept_cnt)
        , .reject_cnt  (reject_cnt)
        , .timeout_cnt (timeout_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the
    // handshake edge (N0).
    task automatic send_req(input logic [1:0] l, output bit ok);
        req_lang_cer = l;
        req_valid    = 1'b1;
        ok           = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max, output int n);
        n = 0;
        while (!rsp_valid && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bit ok;
        int n;

        // Reset values (asynchronous assertion)
        #1 rst_n = 1'b0;
        #2;
        chk("rst_kore_sub", kore_sub, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lang_cer", lang_cer, NONE);
        chk("rst_rsp_approval", rsp_approval, UNKNOWN);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready_low", req_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);
        $display("reset done: req_ready=%0d busy=%0d", req_ready, busy);

        // 1: NONE -> ACCEPT, rsp_valid exactly 2 edges after handshake
        send_req(NONE, ok);
        chk("t1_handshake", ok, 1);
        chk("t1_kore_sub", kore_sub, 1);
        chk("t1_busy", busy, 1);
        chk("t1_req_ready", req_ready, 0);
        @(negedge clk);
        chk("t1_rsp_valid_early", rsp_valid, 0);
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_approval", rsp_approval, ACCEPT);
        chk("t1_timeout", rsp_timeout, 0);
        chk("t1_kore_sub_drop", kore_sub, 0);
        $display("txn1: lang=NONE approval=%0d timeout=%0d", rsp_approval, rsp_timeout);
        wait_idle(ok);
        chk("t1_idle", ok, 1);
`ifdef COASIA_APPLICANT_STATS_EN
        chk("t1_accept_cnt", accept_cnt, 1);
`endif

        // 2: non-NONE -> REJECT, then back-to-back NONE -> ACCEPT
        send_req(TOPIK, ok);
        chk("t2a_handshake", ok, 1);
        chk("t2a_lang_cer", lang_cer, TOPIK);
        wait_rsp(40, n);
        chk("t2a_latency", n, 2);
        chk("t2a_approval", rsp_approval, REJECT);
        $display("txn2a: lang=TOPIK approval=%0d latency=%0d", rsp_approval, n);
        @(negedge clk);
        send_req(NONE, ok);
        chk("t2b_handshake", ok, 1);
        wait_rsp(40, n);
        chk("t2b_latency", n, 2);
        chk("t2b_approval", rsp_approval, ACCEPT);
        $display("txn2b: lang=NONE approval=%0d latency=%0d", rsp_approval, n);
        wait_idle(ok);

        // 3: responder stuck at UNKNOWN -> timeout after 16 WAIT cycles
        stub_en  = 1'b1;
        stub_val = UNKNOWN;
        send_req(NONE, ok);
        chk("t3_handshake", ok, 1);
        wait_rsp(60, n);
        chk("t3_latency", n, 17);
        chk("t3_timeout", rsp_timeout, 1);
        chk("t3_approval", rsp_approval, UNKNOWN);
        $display("txn3: timeout=%0d approval=%0d latency=%0d", rsp_timeout, rsp_approval, n);
        wait_idle(ok);
        chk("t3_idle", ok, 1);
`ifdef COASIA_APPLICANT_STATS_EN
        chk("t3_timeout_cnt", timeout_cnt, 1);
`endif

        // 3b: illegal code 3 ignored, ACCEPT lands on the expiry cycle and
        // wins; GAP then holds while the verdict is still present
        stub_val = 2'd3;
        send_req(NONE, ok);
        chk("t3b_handshake", ok, 1);
        repeat (16) @(negedge clk);
        chk("t3b_no_rsp_yet", rsp_valid, 0);
        stub_val = ACCEPT;
        @(negedge clk);
        chk("t3b_rsp_valid", rsp_valid, 1);
        chk("t3b_approval", rsp_approval, ACCEPT);
        chk("t3b_timeout", rsp_timeout, 0);
        $display("txn3b: verdict on expiry cycle approval=%0d timeout=%0d", rsp_approval, rsp_timeout);
        repeat (5) @(negedge clk);
        chk("t3b_gap_busy", busy, 1);
        chk("t3b_gap_ready", req_ready, 0);
        chk("t3b_gap_lang", lang_cer, NONE);
        stub_val = UNKNOWN;
        wait_idle(ok);
        chk("t3b_idle", ok, 1);
        stub_en = 1'b0;

        // 4: rsp_ready held low; response stable, new request stalled
        rsp_ready = 1'b0;
        send_req(NONE, ok);
        chk("t4_handshake", ok, 1);
        wait_rsp(40, n);
        chk("t4_latency", n, 2);
        req_lang_cer = KIIP;
        req_valid    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", rsp_valid, 1);
            chk("t4_hold_approval", rsp_approval, ACCEPT);
            chk("t4_hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        send_req(KIIP, ok);
        chk("t4_stalled_handshake", ok, 1);
        wait_rsp(40, n);
        chk("t4_latency2", n, 2);
        chk("t4_approval2", rsp_approval, REJECT);
        $display("txn4: stalled request approval=%0d latency=%0d", rsp_approval, n);
        wait_idle(ok);

        // 5: reset during WAIT
        send_req(NONE, ok);
        chk("t5_handshake", ok, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_kore_sub", kore_sub, 0);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_req_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle(ok);
        chk("t5_idle", ok, 1);
        send_req(NONE, ok);
        chk("t5_handshake2", ok, 1);
        wait_rsp(40, n);
        chk("t5_latency", n, 2);
        chk("t5_approval", rsp_approval, ACCEPT);
        $display("txn5: after reset approval=%0d latency=%0d", rsp_approval, n);
        wait_idle(ok);

`ifdef COASIA_APPLICANT_STATS_EN
        // 6: counters after reset, then saturation
        chk("t6_accept_cnt", accept_cnt, 1);
        chk("t6_reject_cnt", reject_cnt, 0);
        chk("t6_timeout_cnt", timeout_cnt, 0);
        for (int i = 0; i < 19; i++) begin
            send_req(NONE, ok);
            wait_rsp(40, n);
            wait_idle(ok);
        end
        chk("t6_accept_sat", accept_cnt, 4'hF);
        $display("txn6: accept_cnt=%0d after saturation run", accept_cnt);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
